// File: rtl/dna_pkg.sv
// Shared constants and state encoding for the device-DNA read scheduler.
package dna_pkg;

   localparam int unsigned DNA_BITS = 57;
   localparam int unsigned CNT_W    = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_SERVE = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant; the pointer moves past each winner.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic         clk_48,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] gnt
);

   localparam int unsigned PW = $clog2(N);

   logic [PW-1:0] ptr;
   logic [PW-1:0] nxt_ptr_c;
   logic [PW-1:0] idx_c;
   logic [N-1:0]  win_c;
   logic          found_c;

   // First requester at or after the pointer, wrapping around
   always_comb begin
      win_c     = '0;
      nxt_ptr_c = ptr;
      found_c   = 1'b0;
      idx_c     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx_c = PW'((32'(ptr) + i) % N);
         if (!found_c && req[idx_c]) begin
            found_c      = 1'b1;
            win_c[idx_c] = 1'b1;
            nxt_ptr_c    = (idx_c == PW'(N - 1)) ? '0 : idx_c + PW'(1);
         end
      end
   end

   always_ff @(posedge clk_48 or posedge rst) begin
      if (rst) begin
         gnt <= '0;
         ptr <= '0;
      end else begin
         gnt <= en ? win_c : '0;
         if (en && found_c) ptr <= nxt_ptr_c;
      end
   end

endmodule

// File: rtl/dna_read_sched.sv
// Owns the DNA_PORT pins: reads the 57-bit ID once over a divided serial clock,
// caches it and hands it out to requesters with round-robin grants.
module dna_read_sched
   import dna_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned CLK_DIV = 16
) (
   input  logic                clk_48,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic                refresh,
   output logic [NREQ-1:0]     gnt,
   output logic [DNA_BITS-1:0] dna,
   output logic                dna_valid,
   output logic                busy,
   output logic                dna_clk,
   output logic                dna_read,
   output logic                dna_shift,
   input  logic                dna_dout
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

   state_t              state;
   state_t              state_nxt;
   logic [DIV_W-1:0]    div;
   logic [CNT_W-1:0]    cnt;
   logic [DNA_BITS-1:0] cap;
   logic                refresh_pend;

   logic                run_c;
   logic                tick_c;
   logic                fall_c;
   logic                done_c;
   logic                pend_c;
   logic                start_c;
   logic                complete_c;
   logic                arb_en_c;
   logic [NREQ-1:0]     arb_req_c;

   always_ff @(posedge clk_48 or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state plus the strobes that steer the serial datapath
   always_comb begin
      state_nxt  = state;
      done_c     = (state == ST_SHIFT) && (cnt == CNT_W'(DNA_BITS));
      run_c      = ((state == ST_LOAD) || (state == ST_SHIFT)) && !done_c;
      tick_c     = run_c && (div == '0);
      fall_c     = tick_c && dna_clk;
      pend_c     = refresh_pend || refresh;
      start_c    = 1'b0;
      complete_c = 1'b0;
      arb_en_c   = 1'b0;

      case (state)
         ST_IDLE:  if (|req)   state_nxt = ST_LOAD;
         ST_LOAD:  if (fall_c) state_nxt = ST_SHIFT;
         ST_SHIFT: if (done_c) state_nxt = pend_c ? ST_LOAD : ST_SERVE;
         ST_SERVE: if (refresh) state_nxt = ST_LOAD;
         default:  state_nxt = ST_IDLE;
      endcase

      start_c    = (state_nxt == ST_LOAD) && (state != ST_LOAD);
      complete_c = done_c && !pend_c;
      arb_en_c   = complete_c || ((state == ST_SERVE) && !refresh);
   end

   always_ff @(posedge clk_48 or posedge rst) begin
      if (rst) begin
         div          <= DIV_RELOAD;
         cnt          <= '0;
         cap          <= '0;
         refresh_pend <= 1'b0;
         dna          <= '0;
         dna_valid    <= 1'b0;
         busy         <= 1'b0;
         dna_clk      <= 1'b0;
         dna_read     <= 1'b0;
         dna_shift    <= 1'b0;
      end else begin
         busy <= (state_nxt == ST_LOAD) || (state_nxt == ST_SHIFT);
         if (start_c) begin
            div          <= DIV_RELOAD;
            cnt          <= '0;
            refresh_pend <= 1'b0;
            dna_clk      <= 1'b0;
            dna_read     <= 1'b1;
            dna_shift    <= 1'b0;
         end else begin
            if (run_c) div <= tick_c ? DIV_RELOAD : div - DIV_W'(1);
            if (!run_c)      dna_clk <= 1'b0;
            else if (tick_c) dna_clk <= ~dna_clk;
            // Capture on the falling edge; SHIFT drops after the last bit
            if (fall_c) begin
               dna_read  <= 1'b0;
               dna_shift <= (cnt != CNT_W'(DNA_BITS - 1));
               cap       <= {cap[DNA_BITS-2:0], dna_dout};
               cnt       <= cnt + CNT_W'(1);
            end
            if (refresh && ((state == ST_LOAD) || (state == ST_SHIFT)))
               refresh_pend <= 1'b1;
         end
         if (complete_c) begin
            dna       <= cap;
            dna_valid <= 1'b1;
         end else if ((state == ST_SERVE) && refresh) begin
            dna_valid <= 1'b0;
         end
      end
   end

   // Mask the requester being granted this cycle so a held req is not served twice
   assign arb_req_c = req & ~gnt;

   rr_arbiter #(
      .N (NREQ)
   ) u_arb (
      .clk_48 (clk_48),
      .rst    (rst),
      .req    (arb_req_c),
      .en     (arb_en_c),
      .gnt    (gnt)
   );

endmodule

// File: tb/tb_dna_read_sched.sv
// Directed bench for dna_read_sched with a behavioural DNA_PORT model.
module tb_dna_read_sched;

   localparam logic [56:0] V1 = 57'h1_2345_6789_ABCD_EF;
   localparam logic [56:0] V2 = 57'h0AA_55AA_55AA_55AA;
   localparam logic [56:0] V3 = 57'h1_F0F0_1234_5678_9A;

   logic        clk_48;
   logic        rst;
   logic [3:0]  req;
   logic        refresh;
   logic [3:0]  gnt;
   logic [56:0] dna;
   logic        dna_valid;
   logic        busy;
   logic        dna_clk;
   logic        dna_read;
   logic        dna_shift;
   logic        dna_dout;

   logic [56:0] model_val;
   logic [56:0] model_sr;

   int total;
   int bad;

   dna_read_sched #(
      .NREQ    (4),
      .CLK_DIV (16)
   ) dut (
      .clk_48    (clk_48),
      .rst       (rst),
      .req       (req),
      .refresh   (refresh),
      .gnt       (gnt),
      .dna       (dna),
      .dna_valid (dna_valid),
      .busy      (busy),
      .dna_clk   (dna_clk),
      .dna_read  (dna_read),
      .dna_shift (dna_shift),
      .dna_dout  (dna_dout)
   );

   initial clk_48 = 1'b0;
   always #5 clk_48 = ~clk_48;

   // DNA_PORT: load on READ, shift left on SHIFT, MSB drives DOUT
   always @(posedge dna_clk) begin
      if (dna_read)       model_sr <= model_val;
      else if (dna_shift) model_sr <= {model_sr[55:0], 1'b0};
   end
   assign dna_dout = model_sr[56];

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_48);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic       seen_gnt;
      logic       seen_valid;
      logic       seen_busy;
      logic [3:0] exp_g;

      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      req       = 4'b0000;
      refresh   = 1'b0;
      model_val = V1;
      model_sr  = '0;

      // Reset values
      step(2);
      chk("rst_gnt",   64'(gnt),       64'(0));
      chk("rst_dna",   64'(dna),       64'(0));
      chk("rst_valid", 64'(dna_valid), 64'(0));
      chk("rst_busy",  64'(busy),      64'(0));
      chk("rst_pins",  64'({dna_clk, dna_read, dna_shift}), 64'(0));
      rst = 1'b0;
      step(1);

      // First read: req[3] held, req[1] pulsed for 3 cycles mid-read
      req        = 4'b1000;
      seen_gnt   = 1'b0;
      seen_valid = 1'b0;
      for (int c = 1; c <= 1825; c++) begin
         step(1);
         if (c == 1) begin
            chk("load_read", 64'(dna_read), 64'(1));
            chk("load_busy", 64'(busy),     64'(1));
         end
         if (c == 16) chk("clk_before_rise", 64'(dna_clk), 64'(0));
         if (c == 17) chk("clk_first_rise",  64'(dna_clk), 64'(1));
         if (c == 33) chk("first_fall_pins", 64'({dna_clk, dna_read, dna_shift}), 64'(3'b001));
         if (c == 3) req[1] = 1'b1;
         if (c == 6) req[1] = 1'b0;
         if (gnt != 4'b0000) seen_gnt = 1'b1;
         if (dna_valid)      seen_valid = 1'b1;
         if (c == 1825) chk("busy_last_capture", 64'(busy), 64'(1));
      end
      chk("no_gnt_during_read",   64'(seen_gnt),   64'(0));
      chk("no_valid_during_read", 64'(seen_valid), 64'(0));
      step(1);
      chk("first_gnt",   64'(gnt),       64'(4'b1000));
      chk("first_dna",   64'(dna),       64'(V1));
      chk("first_valid", 64'(dna_valid), 64'(1));
      chk("first_busy",  64'(busy),      64'(0));
      chk("idle_pins",   64'({dna_clk, dna_read, dna_shift}), 64'(0));
      req = 4'b0000;
      step(1);
      chk("gnt_single_pulse", 64'(gnt), 64'(0));

      // Cache hit: all four requesters, round robin from 0
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         step(1);
         exp_g = 4'b0001 << i;
         chk("rr_grant", 64'(gnt), 64'(exp_g));
         req[i] = 1'b0;
      end
      seen_gnt  = 1'b0;
      seen_busy = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step(1);
         if (gnt != 4'b0000) seen_gnt = 1'b1;
         if (busy)           seen_busy = 1'b1;
      end
      chk("rr_no_extra_gnt", 64'(seen_gnt),  64'(0));
      chk("rr_no_hw_read",   64'(seen_busy), 64'(0));

      // Refresh with simultaneous req[2]: refresh wins, new value served after read
      model_val  = V2;
      refresh    = 1'b1;
      req        = 4'b0100;
      seen_gnt   = 1'b0;
      seen_valid = 1'b0;
      for (int c = 1; c <= 1825; c++) begin
         step(1);
         if (c == 1) refresh = 1'b0;
         if (gnt != 4'b0000) seen_gnt = 1'b1;
         if (dna_valid)      seen_valid = 1'b1;
      end
      chk("refresh_valid_low", 64'(seen_valid), 64'(0));
      chk("refresh_no_gnt",    64'(seen_gnt),   64'(0));
      step(1);
      chk("refresh_gnt",   64'(gnt),       64'(4'b0100));
      chk("refresh_dna",   64'(dna),       64'(V2));
      chk("refresh_valid", 64'(dna_valid), 64'(1));
      req = 4'b0000;
      step(1);

      // Refresh mid-SHIFT forces a second full read
      refresh = 1'b1;
      for (int c = 1; c <= 3651; c++) begin
         step(1);
         if (c == 1)   refresh = 1'b0;
         if (c == 100) model_val = V3;
         if (c == 900) refresh = 1'b1;
         if (c == 901) refresh = 1'b0;
         if (c == 1826) begin
            chk("pend_no_valid", 64'(dna_valid), 64'(0));
            chk("pend_busy",     64'(busy),      64'(1));
            chk("pend_dna_held", 64'(dna),       64'(V2));
         end
         if (c == 3650) chk("pend_valid_late", 64'(dna_valid), 64'(0));
      end
      chk("pend_valid", 64'(dna_valid), 64'(1));
      chk("pend_dna",   64'(dna),       64'(V3));
      chk("pend_idle",  64'(busy),      64'(0));

      // Reset in the middle of a read
      refresh = 1'b1;
      step(1);
      refresh = 1'b0;
      step(499);
      rst = 1'b1;
      #1;
      chk("midrst_pins",  64'({dna_clk, dna_read, dna_shift}), 64'(0));
      chk("midrst_busy",  64'(busy),      64'(0));
      chk("midrst_valid", 64'(dna_valid), 64'(0));
      chk("midrst_dna",   64'(dna),       64'(0));
      step(1);
      rst = 1'b0;
      step(2);
      model_val = V1;
      req       = 4'b0001;
      step(1825);
      chk("restart_no_gnt", 64'(gnt), 64'(0));
      step(1);
      chk("restart_gnt",   64'(gnt),       64'(4'b0001));
      chk("restart_dna",   64'(dna),       64'(V1));
      chk("restart_valid", 64'(dna_valid), 64'(1));
      req = 4'b0000;
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
